seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. It holds a packed hex value, steps through the digits at a prescaled refresh rate and presents one 4-bit nibble per slot on bcd_out, which feeds the downstream hex-to-segment decoder directly. It also drives the digit-enable (anode) lines and the decimal point. New values are applied only at frame boundaries, so a displayed frame never mixes old and new digits.

Parameters:
NUM_DIGITS, 4, number of digits scanned (≥2)
PRESCALE, 50000, clock cycles per digit slot (≥4)
DEAD, 2, cycles at slot start with all anodes off for anti-ghosting (1 ≤ DEAD < PRESCALE)
AN_ACTIVE_LOW, 1, 1 = anode enable active-low, 0 = active-high

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
load  in  1  1-cycle strobe, capture value/dp_in
value  in  4*NUM_DIGITS  packed nibbles, digit 0 = bits [3:0] (rightmost)
dp_in  in  NUM_DIGITS  decimal-point request per digit
blank_lz  in  1  level, enable leading-zero blanking
bcd_out  out  4  nibble for current digit, to decoder
dp_out  out  1  decimal point for current digit
an  out  NUM_DIGITS  one-hot digit enable (polarity per AN_ACTIVE_LOW)
frame_done  out  1  1-cycle pulse at each frame wrap

Behaviour:
- Reset (async, rst_n=0): cnt=0, digit=0, disp_val=0, disp_dp=0, pend_val=0, pend_dp=0, pend_valid=0. Outputs: an=all inactive, bcd_out=0, dp_out=0, frame_done=0. Outputs change immediately on reset assertion, including mid-frame.
- Prescaler: cnt counts 0..PRESCALE-1 and wraps to 0. On wrap, digit advances 0→1→…→NUM_DIGITS-1→0.
- Frame wrap: cycle where cnt==PRESCALE-1 and digit==NUM_DIGITS-1.
- Load: load=1 writes value/dp_in into pend_*, pend_valid=1. Multiple loads within one frame: last one wins.
- Commit at frame wrap edge:
  - If pend_valid: disp_* <= pend_*, pend_valid <= 0.
  - If load coincides with the frame wrap: the incoming value/dp_in commit directly to disp_* (bypass), pend_valid <= 0.
  - Loads never alter disp_* mid-frame.
- Digit slot, combinational from (digit, cnt, disp_*), then registered into outputs (1-cycle latency):
  - bcd_out = disp_val nibble[digit] for the whole slot.
  - dp_out = disp_dp[digit] while anode active, else 0.
  - anode for digit is active iff cnt ≥ DEAD and the digit is not blanked. All other anodes are inactive.
- Leading-zero blanking: with blank_lz=1, digit i (i ≥ 1) is blanked if nibbles NUM_DIGITS-1 down to i of disp_val are all zero. Digit 0 is never blanked. A blanked digit with dp set stays blanked.
- frame_done: registered, asserted the cycle after the frame-wrap edge, and coincides with the first cycle of the new disp_*.
- Widths: cnt is $clog2(PRESCALE) bits; digit is $clog2(NUM_DIGITS) bits. Non-power-of-2 NUM_DIGITS must wrap explicitly at NUM_DIGITS-1.

Decomposition:
- Shared display package: per-digit nibble width constant (4), anode polarity helper function, and the frame-wrap/prescale defaults.
- One natural sub-module: seg_prescaler (terminal-count counter, outputs slot_tick and cnt). The scan/commit/blank logic stays in seg_scan_ctrl.
- The decoder is instantiated by the parent, not inside this block.

Test Plan:
All scenarios use NUM_DIGITS=4, PRESCALE=8, DEAD=2, AN_ACTIVE_LOW=1.
1. Reset: hold rst_n=0 → an=4'b1111, bcd_out=0, dp_out=0, frame_done=0. Release → first 2 slot cycles an=4'b1111, bcd_out=0.
2. Load 16'h12A4, dp_in=4'b0100, blank_lz=0 → after the next frame_done, slots show bcd_out 4,A,2,1 with an 1110,1101,1011,0111. Each slot is 6 active + 2 dead cycles. dp_out=1 only in digit 2's active cycles.
3. blank_lz=1, value 16'h0030 → digits 3,2 an stay 1111, digit 1 shows 3, digit 0 shows 0. Value 16'h0000 → only digit 0 active.
4. Load 16'h5555 mid-frame (digit 1, cnt 3) → remainder of frame shows the old value. New value appears starting at digit 0 after the frame_done pulse.
5. Two loads in one frame (16'h1111 then 16'h2222) → only 2222 is ever displayed.
6. Load 16'hBEEF exactly on the frame-wrap cycle → next frame shows F,E,E,B with no extra frame of delay. pend_valid=0 afterwards.
7. Assert rst_n=0 during digit 2 active → an=1111 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   NIBBLE_W      : bits per displayed digit (hex nibble)
//   DEF_*         : default geometry/timing for the scan controller
//   an_level()    : maps a logical "digit on" to the physical anode level
package seg_scan_ctrl_pkg;

  localparam int NIBBLE_W          = 4;
  localparam int DEF_NUM_DIGITS    = 4;
  localparam int DEF_PRESCALE      = 50000;
  localparam int DEF_DEAD          = 2;
  localparam int DEF_AN_ACTIVE_LOW = 1;

  // Physical anode level for a logical enable; active-low boards invert.
  function automatic logic an_level(input logic on, input logic active_low);
    return on ^ active_low;
  endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Terminal-count prescaler for the digit slot timer.
//   clk, rst_n : clock, asynchronous active-low reset
//   cnt        : position inside the current slot, 0..PRESCALE-1
//   slot_tick  : high on the last cycle of a slot (cnt == PRESCALE-1)
module seg_prescaler
  import seg_scan_ctrl_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE,
  localparam int CW      = $clog2(PRESCALE)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] cnt,
  output logic          slot_tick
);

  localparam logic [CW-1:0] TC = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    slot_tick = (cnt_q == TC);
    cnt_d     = slot_tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit seven-segment display.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : 1-cycle strobe capturing value/dp_in (no back-pressure:
//                every strobe is accepted; the last one before a frame wrap
//                is the one that gets displayed)
//   value      : packed nibbles, digit 0 in bits [3:0]
//   dp_in      : decimal-point request per digit
//   blank_lz   : enable leading-zero blanking
//   bcd_out    : nibble for the digit being scanned (to external decoder)
//   dp_out     : decimal point for the digit being scanned
//   an         : one-hot digit enable, polarity set by AN_ACTIVE_LOW
//   frame_done : 1-cycle pulse, first cycle of each new frame
// All outputs are registered, so they lag the internal scan state by 1 cycle.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS    = DEF_NUM_DIGITS,
  parameter int PRESCALE      = DEF_PRESCALE,
  parameter int DEAD          = DEF_DEAD,
  parameter int AN_ACTIVE_LOW = DEF_AN_ACTIVE_LOW
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]          dp_in,
  input  logic                           blank_lz,
  output logic [NIBBLE_W-1:0]            bcd_out,
  output logic                           dp_out,
  output logic [NUM_DIGITS-1:0]          an,
  output logic                           frame_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int VW = NIBBLE_W * NUM_DIGITS;

  localparam logic [CW-1:0]         DEAD_C   = CW'(DEAD);
  localparam logic [DW-1:0]         DIG_LAST = DW'(NUM_DIGITS - 1);
  localparam logic                  AN_LOW   = (AN_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_LOW}};

  logic [CW-1:0] cnt;
  logic          slot_tick;

  seg_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt       (cnt),
    .slot_tick (slot_tick)
  );

  logic [DW-1:0]         digit_q,      digit_d;
  logic [VW-1:0]         disp_val_q,   disp_val_d;
  logic [NUM_DIGITS-1:0] disp_dp_q,    disp_dp_d;
  logic [VW-1:0]         pend_val_q,   pend_val_d;
  logic [NUM_DIGITS-1:0] pend_dp_q,    pend_dp_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0] an_q,         an_d;
  logic [NIBBLE_W-1:0]   bcd_q,        bcd_d;
  logic                  dp_q,         dp_d;

  logic frame_wrap;

  // Digit stepping and the pending/displayed value pipeline.
  always_comb begin
    frame_wrap   = slot_tick && (digit_q == DIG_LAST);
    digit_d      = digit_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    frame_done_d = frame_wrap;

    // Explicit wrap so non-power-of-2 digit counts work.
    if (slot_tick) digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;

    if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end

    // A load on the wrap cycle goes straight to the display so it is not
    // held back a whole frame.
    if (frame_wrap) begin
      if (load) begin
        disp_val_d = value;
        disp_dp_d  = dp_in;
      end else if (pend_valid_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
      pend_valid_d = 1'b0;
    end
  end

  // Per-slot output decode from the current scan position.
  logic                  all_zero;
  logic                  blanked;
  logic                  slot_on;
  logic [NIBBLE_W-1:0]   nib;
  logic                  dp_bit;

  always_comb begin
    nib      = '0;
    dp_bit   = 1'b0;
    all_zero = 1'b1;
    blanked  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_q == DW'(i)) begin
        nib    = disp_val_q[i*NIBBLE_W +: NIBBLE_W];
        dp_bit = disp_dp_q[i];
      end
    end
    // Walk from the most significant digit down: a digit is a leading zero
    // when it and everything above it are zero. Digit 0 is never visited.
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (disp_val_q[i*NIBBLE_W +: NIBBLE_W] != '0) all_zero = 1'b0;
      if ((digit_q == DW'(i)) && all_zero) blanked = 1'b1;
    end
    slot_on = (cnt >= DEAD_C) && !(blank_lz && blanked);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = an_level(slot_on && (digit_q == DW'(i)), AN_LOW);
    end
    bcd_d = nib;
    dp_d  = slot_on && dp_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q      <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= AN_OFF;
      bcd_q        <= '0;
      dp_q         <= 1'b0;
    end else begin
      digit_q      <= digit_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      bcd_q        <= bcd_d;
      dp_q         <= dp_d;
    end
  end

  assign bcd_out    = bcd_q;
  assign dp_out     = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, PRESCALE=8, DEAD=2,
// active-low anodes. Each frame is 32 cycles; run_frame walks one frame and
// checks every output cycle against hand-specified digit/lit/dp patterns.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  bcd_out;
  logic        dp_out;
  logic [3:0]  an;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS    (4),
    .PRESCALE      (8),
    .DEAD          (2),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .bcd_out    (bcd_out),
    .dp_out     (dp_out),
    .an         (an),
    .frame_done (frame_done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Walk one 32-cycle frame starting with the scan state at digit 0, cnt 0.
  // nibs/lit/dpm describe what the frame must show; up to two loads are
  // injected at frame-relative cycles la1/la2 (-1 = none).
  task automatic run_frame(input string tag,
                           input logic [15:0] nibs, input logic [3:0] lit,
                           input logic [3:0] dpm,
                           input int la1, input logic [15:0] lv1, input logic [3:0] ld1,
                           input int la2, input logic [15:0] lv2, input logic [3:0] ld2);
    int d;
    int c;
    logic [3:0] onehot;
    logic [3:0] an_exp;
    logic on;
    for (int k = 1; k <= 32; k++) begin
      if (k - 1 == la1) begin
        load = 1'b1; value = lv1; dp_in = ld1;
      end else if (k - 1 == la2) begin
        load = 1'b1; value = lv2; dp_in = ld2;
      end else begin
        load = 1'b0;
      end
      step();
      load   = 1'b0;
      d      = (k - 1) / 8;
      c      = (k - 1) % 8;
      on     = (c >= 2) && lit[d];
      onehot = 4'b0001 << d;
      an_exp = on ? ~onehot : 4'b1111;
      chk($sformatf("%s k%0d an", tag, k), 32'(an), 32'(an_exp));
      chk($sformatf("%s k%0d bcd", tag, k), 32'(bcd_out), 32'(nibs[d*4 +: 4]));
      chk($sformatf("%s k%0d dp", tag, k), 32'(dp_out), 32'(on && dpm[d]));
      chk($sformatf("%s k%0d fd", tag, k), 32'(frame_done), 32'(k == 32));
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    value    = '0;
    dp_in    = '0;
    blank_lz = 1'b0;

    // Reset held: outputs idle.
    repeat (3) step();
    chk("rst an",  32'(an),         32'hF);
    chk("rst bcd", 32'(bcd_out),    32'h0);
    chk("rst dp",  32'(dp_out),     32'h0);
    chk("rst fd",  32'(frame_done), 32'h0);
    rst_n = 1'b1;

    // Frame 1: zero value, no blanking -> all digits show 0; load 12A4 mid-frame.
    run_frame("f1", 16'h0000, 4'b1111, 4'b0000,
              10, 16'h12A4, 4'b0100, -1, 16'h0, 4'h0);
    // Frame 2: 4,A,2,1 with dp on digit 2; queue 0030 (dp on blanked digit 3).
    run_frame("f2", 16'h12A4, 4'b1111, 4'b0100,
              6, 16'h0030, 4'b1000, -1, 16'h0, 4'h0);
    blank_lz = 1'b1;
    // Frame 3: digits 3,2 blanked; dp request on digit 3 stays dark.
    run_frame("f3", 16'h0030, 4'b0011, 4'b1000,
              25, 16'h0000, 4'b0001, -1, 16'h0, 4'h0);
    // Frame 4: only digit 0 lit; load 5555 at digit 1 cnt 3 must not show yet.
    run_frame("f4", 16'h0000, 4'b0001, 4'b0001,
              11, 16'h5555, 4'b0000, -1, 16'h0, 4'h0);
    // Frame 5: 5555; two loads, last one wins.
    run_frame("f5", 16'h5555, 4'b1111, 4'b0000,
              5, 16'h1111, 4'b0001, 20, 16'h2222, 4'b0010);
    // Frame 6: 2222; load BEEF exactly on the wrap cycle.
    run_frame("f6", 16'h2222, 4'b1111, 4'b0010,
              31, 16'hBEEF, 4'b1001, -1, 16'h0, 4'h0);
    // Frame 7: BEEF bypassed straight in, no extra frame of delay.
    run_frame("f7", 16'hBEEF, 4'b1111, 4'b1001,
              -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    // Frame 8: stop inside digit 2's active window, then reset asynchronously.
    repeat (20) step();
    chk("pre-rst an",  32'(an),      32'hB);
    chk("pre-rst bcd", 32'(bcd_out), 32'hE);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async an",  32'(an),         32'hF);
    chk("async bcd", 32'(bcd_out),    32'h0);
    chk("async dp",  32'(dp_out),     32'h0);
    chk("async fd",  32'(frame_done), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
